// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared FSM encodings and head-flit field layout for the NI bridge
package noc_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HEAD = 2'd1,
        TX_BODY = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_WAIT_HEAD = 1'b0,
        RX_WAIT_BODY = 1'b1
    } rx_state_e;

    // Head flit: flag in the MSB, dest in the low NODE_W bits, src directly above it.
    localparam int HEAD_DEST_LSB = 0;

    function automatic int head_src_lsb(input int node_w);
        return node_w;
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// rtl/ni_fifo.sv - synchronous power-of-two FIFO with registered occupancy count
module ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/proc_ni_bridge.sv
// rtl/proc_ni_bridge.sv - processor-to-NoC bridge: word to head/body flit pairs and back
module proc_ni_bridge
    import noc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NODE_W   = 2,
    parameter int NODE_ID  = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        proc_valid,
    input  logic [NODE_W-1:0]           proc_dest,
    input  logic [DATA_W-1:0]           proc_data,
    output logic                        proc_ready,
    output logic [DATA_W:0]             flit_out,
    output logic                        flit_out_valid,
    input  logic                        flit_out_ready,
    input  logic [DATA_W:0]             flit_in,
    input  logic                        flit_in_valid,
    output logic                        flit_in_ready,
    output logic                        rx_valid,
    output logic [DATA_W-1:0]           rx_data,
    output logic [NODE_W-1:0]           rx_src,
    input  logic                        rx_pop,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        drop_err
);
    localparam int EW      = NODE_W + DATA_W;
    localparam int TCW     = $clog2(TX_DEPTH) + 1;
    localparam int SRC_LSB = head_src_lsb(NODE_W);
    localparam int PAD_W   = DATA_W - 2*NODE_W;
    localparam logic [NODE_W-1:0] MY_ID = NODE_W'(NODE_ID);

    // ---------------- transmit path ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [EW-1:0]     tx_rdata;
    logic [NODE_W-1:0] tx_dest;
    logic [DATA_W-1:0] tx_data;

    assign proc_ready = ~tx_full;
    assign tx_push    = proc_valid & proc_ready;
    assign tx_dest    = tx_rdata[EW-1 -: NODE_W];
    assign tx_data    = tx_rdata[DATA_W-1:0];

    ni_fifo #(.WIDTH(EW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata ({proc_dest, proc_data}),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // An entry being written this cycle already counts as pending so the head follows next cycle.
    always_comb begin
        tx_state_d     = tx_state_q;
        tx_pop         = 1'b0;
        flit_out_valid = 1'b0;
        flit_out       = '0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty || tx_push) tx_state_d = TX_HEAD;
            end
            TX_HEAD: begin
                flit_out_valid = 1'b1;
                flit_out       = {1'b1, {PAD_W{1'b0}}, MY_ID, tx_dest};
                if (flit_out_ready) tx_state_d = TX_BODY;
            end
            TX_BODY: begin
                flit_out_valid = 1'b1;
                flit_out       = {1'b0, tx_data};
                if (flit_out_ready) begin
                    tx_pop     = 1'b1;
                    tx_state_d = (tx_count > TCW'(1) || tx_push) ? TX_HEAD : TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) tx_state_q <= TX_IDLE;
        else     tx_state_q <= tx_state_d;
    end

    // ---------------- receive path ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [NODE_W-1:0] src_q, src_d;
    logic              discard_q, discard_d;
    logic              drop_err_q, drop_set;
    logic              rx_push, rx_full, rx_empty, in_accept, in_is_head, dest_bad;
    logic [EW-1:0]     rx_rdata;

    assign flit_in_ready = (rx_state_q == RX_WAIT_HEAD) || !rx_full;
    assign in_accept     = flit_in_valid & flit_in_ready;
    assign in_is_head    = flit_in[DATA_W];
    assign dest_bad      = (flit_in[HEAD_DEST_LSB +: NODE_W] != MY_ID);

    ni_fifo #(.WIDTH(EW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata ({src_q, flit_in[DATA_W-1:0]}),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_valid = ~rx_empty;
    assign rx_src   = rx_rdata[EW-1 -: NODE_W];
    assign rx_data  = rx_rdata[DATA_W-1:0];
    assign drop_err = drop_err_q;

    // A misaddressed head still opens a packet, flagged so its body is swallowed.
    always_comb begin
        rx_state_d = rx_state_q;
        src_d      = src_q;
        discard_d  = discard_q;
        drop_set   = 1'b0;
        rx_push    = 1'b0;
        if (in_accept) begin
            if (in_is_head) begin
                src_d      = flit_in[SRC_LSB +: NODE_W];
                discard_d  = dest_bad;
                drop_set   = dest_bad || (rx_state_q == RX_WAIT_BODY);
                rx_state_d = RX_WAIT_BODY;
            end else if (rx_state_q == RX_WAIT_BODY) begin
                rx_push    = ~discard_q;
                rx_state_d = RX_WAIT_HEAD;
            end else begin
                drop_set   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_WAIT_HEAD;
            src_q      <= '0;
            discard_q  <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            src_q      <= src_d;
            discard_q  <= discard_d;
            drop_err_q <= drop_err_q | drop_set;
        end
    end

endmodule

// File: tb/tb_proc_ni_bridge.sv
// tb/tb_proc_ni_bridge.sv - directed vector and corner-sequence bench for proc_ni_bridge
module tb_proc_ni_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_valid;
    logic [1:0]  proc_dest;
    logic [31:0] proc_data;
    logic        proc_ready;
    logic [32:0] flit_out;
    logic        flit_out_valid;
    logic        flit_out_ready;
    logic [32:0] flit_in;
    logic        flit_in_valid;
    logic        flit_in_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic [1:0]  rx_src;
    logic        rx_pop;
    logic [2:0]  tx_count;
    logic [2:0]  rx_count;
    logic        drop_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_ni_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .proc_valid     (proc_valid),
        .proc_dest      (proc_dest),
        .proc_data      (proc_data),
        .proc_ready     (proc_ready),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .flit_in        (flit_in),
        .flit_in_valid  (flit_in_valid),
        .flit_in_ready  (flit_in_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_src         (rx_src),
        .rx_pop         (rx_pop),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .drop_err       (drop_err)
    );

    typedef struct {
        logic        pv;
        logic [1:0]  pd;
        logic [31:0] pdata;
        logic        fo_rdy;
        logic [32:0] fi;
        logic        fi_v;
        logic        pop;
        logic        e_pr;
        logic        e_fov;
        logic [32:0] e_fo;
        logic        e_fir;
        logic        e_rxv;
        logic [31:0] e_rxd;
        logic [1:0]  e_rxs;
        logic [2:0]  e_txc;
        logic [2:0]  e_rxc;
        logic        e_drop;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t idle_row();
        vec_t v;
        v = '{pv: 1'b0, pd: 2'd0, pdata: 32'd0, fo_rdy: 1'b0, fi: 33'd0, fi_v: 1'b0,
              pop: 1'b0, e_pr: 1'b1, e_fov: 1'b0, e_fo: 33'd0, e_fir: 1'b1, e_rxv: 1'b0,
              e_rxd: 32'd0, e_rxs: 2'd0, e_txc: 3'd0, e_rxc: 3'd0, e_drop: 1'b0};
        return v;
    endfunction

    function automatic logic [32:0] head(input logic [1:0] src, input logic [1:0] dest);
        return {1'b1, 28'd0, src, dest};
    endfunction

    function automatic logic [32:0] body(input logic [31:0] d);
        return {1'b0, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h req=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_flit(input logic [32:0] f);
        int n;
        n = 0;
        flit_in = f;
        flit_in_valid = 1'b1;
        #1;
        while (!flit_in_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("flit_in_ready_wait", {63'd0, flit_in_ready}, 64'd1);
        tick();
        flit_in_valid = 1'b0;
    endtask

    logic [32:0] exp_q [8];

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; proc_valid = 1'b0; proc_dest = '0; proc_data = '0;
        flit_out_ready = 1'b0; flit_in = '0; flit_in_valid = 1'b0; rx_pop = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // basic send and receive, one row per cycle
        vecs[0] = idle_row();
        vecs[1] = idle_row(); vecs[1].pv = 1'b1; vecs[1].pd = 2'd2; vecs[1].pdata = 32'hDEADBEEF; vecs[1].fo_rdy = 1'b1;
        vecs[2] = idle_row(); vecs[2].fo_rdy = 1'b1; vecs[2].e_fov = 1'b1; vecs[2].e_fo = 33'h1_00000002; vecs[2].e_txc = 3'd1;
        vecs[3] = idle_row(); vecs[3].fo_rdy = 1'b1; vecs[3].e_fov = 1'b1; vecs[3].e_fo = 33'h0_DEADBEEF; vecs[3].e_txc = 3'd1;
        vecs[4] = idle_row(); vecs[4].fo_rdy = 1'b1;
        vecs[5] = idle_row(); vecs[5].fi = 33'h1_0000000C; vecs[5].fi_v = 1'b1;
        vecs[6] = idle_row(); vecs[6].fi = 33'h0_12345678; vecs[6].fi_v = 1'b1;
        vecs[7] = idle_row(); vecs[7].pop = 1'b1; vecs[7].e_rxv = 1'b1; vecs[7].e_rxd = 32'h12345678;
        vecs[7].e_rxs = 2'd3; vecs[7].e_rxc = 3'd1;
        vecs[8] = idle_row();

        for (int i = 0; i < 9; i++) begin
            proc_valid = vecs[i].pv; proc_dest = vecs[i].pd; proc_data = vecs[i].pdata;
            flit_out_ready = vecs[i].fo_rdy; flit_in = vecs[i].fi; flit_in_valid = vecs[i].fi_v;
            rx_pop = vecs[i].pop;
            #1;
            chk($sformatf("v%0d proc_ready", i), {63'd0, proc_ready}, {63'd0, vecs[i].e_pr});
            chk($sformatf("v%0d flit_out_valid", i), {63'd0, flit_out_valid}, {63'd0, vecs[i].e_fov});
            if (vecs[i].e_fov) chk($sformatf("v%0d flit_out", i), {31'd0, flit_out}, {31'd0, vecs[i].e_fo});
            chk($sformatf("v%0d flit_in_ready", i), {63'd0, flit_in_ready}, {63'd0, vecs[i].e_fir});
            chk($sformatf("v%0d rx_valid", i), {63'd0, rx_valid}, {63'd0, vecs[i].e_rxv});
            if (vecs[i].e_rxv) begin
                chk($sformatf("v%0d rx_data", i), {32'd0, rx_data}, {32'd0, vecs[i].e_rxd});
                chk($sformatf("v%0d rx_src", i), {62'd0, rx_src}, {62'd0, vecs[i].e_rxs});
            end
            chk($sformatf("v%0d tx_count", i), {61'd0, tx_count}, {61'd0, vecs[i].e_txc});
            chk($sformatf("v%0d rx_count", i), {61'd0, rx_count}, {61'd0, vecs[i].e_rxc});
            chk($sformatf("v%0d drop_err", i), {63'd0, drop_err}, {63'd0, vecs[i].e_drop});
            tick();
        end
        proc_valid = 1'b0; flit_in_valid = 1'b0; rx_pop = 1'b0;

        // TX backpressure during HEAD, then fill the TX FIFO and drain in order
        do_reset();
        flit_out_ready = 1'b0;
        proc_valid = 1'b1; proc_dest = 2'd1; proc_data = 32'hA0;
        tick();
        proc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d valid", i), {63'd0, flit_out_valid}, 64'd1);
            chk($sformatf("stall%0d flit", i), {31'd0, flit_out}, {31'd0, head(2'd0, 2'd1)});
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            proc_valid = 1'b1;
            proc_dest = (j == 0) ? 2'd0 : (j == 1) ? 2'd2 : 2'd3;
            proc_data = (j == 0) ? 32'hB1 : (j == 1) ? 32'hC2 : 32'hD3;
            #1;
            chk($sformatf("fill%0d proc_ready", j), {63'd0, proc_ready}, 64'd1);
            tick();
        end
        proc_valid = 1'b0;
        #1;
        chk("tx_full count", {61'd0, tx_count}, 64'd4);
        chk("tx_full proc_ready", {63'd0, proc_ready}, 64'd0);
        proc_valid = 1'b1; proc_dest = 2'd3; proc_data = 32'hEE;
        tick();
        proc_valid = 1'b0;
        #1;
        chk("tx_full reject count", {61'd0, tx_count}, 64'd4);
        exp_q[0] = head(2'd0, 2'd1); exp_q[1] = body(32'hA0);
        exp_q[2] = head(2'd0, 2'd0); exp_q[3] = body(32'hB1);
        exp_q[4] = head(2'd0, 2'd2); exp_q[5] = body(32'hC2);
        exp_q[6] = head(2'd0, 2'd3); exp_q[7] = body(32'hD3);
        begin
            int k;
            int n;
            k = 0;
            n = 0;
            flit_out_ready = 1'b1;
            while (k < 8 && n < 40) begin
                #1;
                if (flit_out_valid) begin
                    chk($sformatf("drain%0d flit", k), {31'd0, flit_out}, {31'd0, exp_q[k]});
                    k++;
                end
                tick();
                n++;
            end
            chk("drain flit total", 64'(k), 64'd8);
        end
        #1;
        chk("drain tx_count", {61'd0, tx_count}, 64'd0);
        chk("drain valid", {63'd0, flit_out_valid}, 64'd0);
        flit_out_ready = 1'b0;

        // RX FIFO full: fifth head is taken, its body waits for a pop
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_flit(head(2'd1, 2'd0));
            push_flit(body(32'h100 + 32'(p)));
        end
        #1;
        chk("rx_fill count", {61'd0, rx_count}, 64'd4);
        push_flit(head(2'd1, 2'd0));
        flit_in = body(32'h104);
        flit_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rx_block%0d ready", i), {63'd0, flit_in_ready}, 64'd0);
            tick();
        end
        rx_pop = 1'b1;
        #1;
        chk("rx_pop_cycle ready", {63'd0, flit_in_ready}, 64'd0);
        tick();
        rx_pop = 1'b0;
        #1;
        chk("rx_after_pop ready", {63'd0, flit_in_ready}, 64'd1);
        tick();
        flit_in_valid = 1'b0;
        #1;
        chk("rx_refill count", {61'd0, rx_count}, 64'd4);
        for (int p = 1; p < 5; p++) begin
            #1;
            chk($sformatf("rx_order%0d valid", p), {63'd0, rx_valid}, 64'd1);
            chk($sformatf("rx_order%0d data", p), {32'd0, rx_data}, {32'd0, 32'h100 + 32'(p)});
            chk($sformatf("rx_order%0d src", p), {62'd0, rx_src}, 64'd1);
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
        #1;
        chk("rx_empty valid", {63'd0, rx_valid}, 64'd0);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        #1;
        chk("rx_pop_empty count", {61'd0, rx_count}, 64'd0);

        // protocol errors: orphan body, misaddressed head and its body
        do_reset();
        #1;
        chk("err pre drop", {63'd0, drop_err}, 64'd0);
        push_flit(body(32'h99));
        #1;
        chk("orphan drop", {63'd0, drop_err}, 64'd1);
        chk("orphan count", {61'd0, rx_count}, 64'd0);
        push_flit(head(2'd2, 2'd1));
        push_flit(body(32'hAA));
        #1;
        chk("misaddr count", {61'd0, rx_count}, 64'd0);
        push_flit(head(2'd2, 2'd0));
        push_flit(body(32'h55));
        #1;
        chk("recover count", {61'd0, rx_count}, 64'd1);
        chk("recover data", {32'd0, rx_data}, 64'h55);
        chk("recover src", {62'd0, rx_src}, 64'd2);
        chk("sticky drop", {63'd0, drop_err}, 64'd1);

        // reset between head and body on TX
        flit_out_ready = 1'b1;
        proc_valid = 1'b1; proc_dest = 2'd2; proc_data = 32'h77;
        tick();
        proc_valid = 1'b0;
        #1;
        chk("mid head", {31'd0, flit_out}, {31'd0, head(2'd0, 2'd2)});
        tick();
        flit_out_ready = 1'b0;
        #1;
        chk("mid body", {31'd0, flit_out}, {31'd0, body(32'h77)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst fov", {63'd0, flit_out_valid}, 64'd0);
        chk("rst tx_count", {61'd0, tx_count}, 64'd0);
        chk("rst rx_count", {61'd0, rx_count}, 64'd0);
        chk("rst proc_ready", {63'd0, proc_ready}, 64'd1);
        chk("rst flit_in_ready", {63'd0, flit_in_ready}, 64'd1);
        chk("rst rx_valid", {63'd0, rx_valid}, 64'd0);
        chk("rst drop_err", {63'd0, drop_err}, 64'd0);
        flit_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk($sformatf("post_rst%0d fov", i), {63'd0, flit_out_valid}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_ni_bridge.md
PROC_NI_BRIDGE -- requirements
Module: proc_ni_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning processor word and flit payload width.
REQ-002 SHALL have parameter NODE_W, default 2, meaning node address width (2**NODE_W nodes).
REQ-003 SHALL have parameter NODE_ID, default 0, meaning this node's address.
REQ-004 SHALL have parameter TX_DEPTH, default 4, meaning transmit FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter RX_DEPTH, default 4, meaning receive FIFO entries (power of two, >=2).
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: proc_valid  in  1  send request; proc_dest  in  NODE_W  destination; proc_data  in  DATA_W  payload; proc_ready  out  1  TX FIFO not full.
REQ-008 SHALL have ports: flit_out  out  DATA_W+1  flit (MSB = head flag); flit_out_valid  out  1; flit_out_ready  in  1.
REQ-009 SHALL have ports: flit_in  in  DATA_W+1  flit; flit_in_valid  in  1; flit_in_ready  out  1.
REQ-010 SHALL have ports: rx_valid  out  1  RX FIFO not empty; rx_data  out  DATA_W; rx_src  out  NODE_W; rx_pop  in  1  consume head entry.
REQ-011 SHALL have ports: tx_count  out  $clog2(TX_DEPTH)+1; rx_count  out  $clog2(RX_DEPTH)+1; drop_err  out  1  sticky.

Function
REQ-012 A send SHALL be accepted on a cycle with proc_valid=1 and proc_ready=1; entry {dest,data} is written to the TX FIFO.
REQ-013 proc_ready SHALL be 1 iff tx_count<TX_DEPTH, evaluated on registered count (no same-cycle pop bypass).
REQ-014 Each entry SHALL be sent as two flits: head {1, zero-pad, NODE_ID, dest} (dest in bits NODE_W-1:0, src in bits 2*NODE_W-1:NODE_W), then body {0, data}.
REQ-015 TX FSM SHALL have states IDLE, HEAD, BODY: IDLE->HEAD when FIFO non-empty; HEAD->BODY on flit_out_valid&flit_out_ready; BODY->HEAD (FIFO non-empty after pop) or IDLE on body handshake.
REQ-016 flit_out_valid SHALL be 1 exactly in HEAD and BODY; flit_out SHALL be held stable while valid and not ready.
REQ-017 The TX FIFO entry SHALL be popped on the body handshake only.
REQ-018 Minimum entry-to-head latency: entry written cycle N, head flit valid cycle N+1 (state registered).
REQ-019 RX FSM SHALL have states WAIT_HEAD, WAIT_BODY; a head flit in WAIT_HEAD latches src and moves to WAIT_BODY; a body flit in WAIT_BODY writes {src,data} to the RX FIFO and returns to WAIT_HEAD.
REQ-020 flit_in_ready SHALL be 1 in WAIT_HEAD, and in WAIT_BODY only when rx_count<RX_DEPTH.
REQ-021 A body flit in WAIT_HEAD or a head flit in WAIT_BODY SHALL be consumed, discarded, set drop_err, and leave the FSM in WAIT_HEAD (head in WAIT_BODY: re-latch, stay WAIT_BODY).
REQ-022 A head flit whose dest field != NODE_ID SHALL set drop_err, and its following body SHALL be discarded.
REQ-023 rx_data/rx_src SHALL show the FIFO head combinationally when rx_valid=1; rx_pop with rx_valid=0 SHALL be ignored.
REQ-024 Simultaneous push and pop on either FIFO SHALL leave its count unchanged; pointers wrap modulo depth.
REQ-025 drop_err SHALL stay 1 until reset.

Reset
REQ-026 On rst=1 at a clk edge: TX FSM->IDLE, RX FSM->WAIT_HEAD, both FIFOs empty, drop_err=0.
REQ-027 After reset: proc_ready=1, flit_out_valid=0, flit_in_ready=1, rx_valid=0, tx_count=0, rx_count=0.
REQ-028 Reset mid-packet SHALL abandon the packet; no partial body flit is emitted afterwards.
REQ-029 FIFO storage arrays SHALL NOT require reset.

Structure
REQ-030 TX/RX state encodings and the head-flit field offsets SHALL live in shared package noc_pkg.
REQ-031 Both FIFOs SHALL be instances of one sub-module ni_fifo (params WIDTH, DEPTH; push/pop/count/full/empty).

Verification
REQ-032 Defaults, send dest=2 data=0xDEADBEEF, flit_out_ready=1 -> head 0x1_00000002 then body 0x0_DEADBEEF on consecutive cycles, tx_count back to 0.
REQ-033 flit_out_ready=0 for 5 cycles during HEAD -> flit_out stable, valid held; 4 more sends fill FIFO -> proc_ready=0 at tx_count=4.
REQ-034 Inject head dest=0 src=3 then body 0x12345678 -> rx_valid=1, rx_src=3, rx_data=0x12345678; rx_pop -> rx_valid=0.
REQ-035 Fill RX FIFO (4 packets, no pop), send fifth head+body -> head accepted, flit_in_ready=0 for body until one rx_pop.
REQ-036 Body flit with no head, then head dest=1 -> drop_err=1, rx_count unchanged.
REQ-037 Assert rst between head and body on TX -> flit_out_valid=0 next cycle, no body emitted, all counts 0.
